fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Packet-level round-robin arbiter that lets NREQ requesters share the single write port of one
//  sfifo instance (DATA_WIDTH=18 buffer). Holds a grant for a requester's whole packet, which ends
//  on the beat whose LAST_BIT is set. Gates writes on FIFO full.
//  Releases a stalled owner after a programmable idle timeout.
//  Sits between the packet sources and the sfifo wr_en/din/full pins. Same clock domain as the FIFO.
// PARAMETERS
//  NREQ       4    number of requesters, 2..8
//  DATA_WIDTH 18   beat width; matches FIFO din
//  LAST_BIT   16   bit index inside a beat that marks end-of-packet
//  TO_WIDTH   8    width of the idle-timeout counter
//  TIMEOUT    255  idle cycles before a forced release; 0 disables the timeout
// PORTS
//  clk           in   1                clock; all state on rising edge
//  rst           in   1                asynchronous, active-high reset
//  req_valid     in   NREQ             requester i has a beat on req_data slice i
//  req_data      in   NREQ*DATA_WIDTH  beat of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready     out  NREQ             beat of requester i is accepted this cycle
//  fifo_full     in   1                FIFO full flag
//  fifo_wr_en    out  1                FIFO write enable
//  fifo_din      out  DATA_WIDTH       FIFO write data
//  grant         out  NREQ             one-hot current owner; zero when idle
//  busy          out  1                1 while in state GRANT
//  timeout_err   out  1                sticky flag: a forced release has occurred
//  err_clr       in   1                synchronous clear of timeout_err
// BEHAVIOUR
//  Reset (async): state=IDLE, owner=0, rr_ptr=0, to_cnt=0, timeout_err=0.
//   All outputs are 0 during reset, including fifo_din.
//  FSM, two states:
//  - IDLE: no output is asserted.
//    If any req_valid is set, search from rr_ptr upward, modulo NREQ. The first valid index becomes
//    owner, and the next state is GRANT. This costs one arbitration bubble cycle.
//  - GRANT: grant=onehot(owner), busy=1.
//    req_ready[owner] = ~fifo_full. Every other req_ready bit is 0.
//    fifo_wr_en = req_valid[owner] & ~fifo_full, combinational.
//    fifo_din = req_data slice of owner, combinational mux. It is 0 when fifo_wr_en=0.
//    Write latency is 0 cycles: the beat reaches the FIFO in the same cycle as the handshake.
//    On a write whose beat has LAST_BIT=1: next state IDLE, and rr_ptr = (owner+1) mod NREQ.
//  - Timeout: in GRANT, to_cnt increments on each cycle with req_valid[owner]=0. It resets to 0 on
//    any write and whenever the FSM leaves GRANT. Stall cycles caused by fifo_full do not count.
//    When TIMEOUT!=0 and to_cnt reaches TIMEOUT:
//    next state IDLE, rr_ptr = owner+1, timeout_err set to 1, and no write occurs that cycle.
//  - A write never occurs while fifo_full=1, so the FIFO never overflows.
//  - When last beat and timeout coincide, the write wins: normal release, and timeout_err is unchanged.
//  - Simultaneous requests in IDLE: the lowest index at or after rr_ptr wins.
//    Requests that lose stay pending. The arbiter keeps no memory of them beyond req_valid.
//  - Requests from other requesters while in GRANT are ignored.
//    They are arbitrated in the IDLE cycle after release.
//  - If err_clr and a new timeout occur in the same cycle, the set wins.
//  - rr_ptr wraps from NREQ-1 to 0.
//    With NREQ not a power of two, unused pointer codes are never reached.
//  - An async rst in mid-packet aborts the packet immediately.
//    The beats already written remain in the FIFO. Handling the partial packet is the consumer's job.
// TESTING
//  T1 reset: assert rst with all req_valid=1 -> grant=0, fifo_wr_en=0, busy=0, timeout_err=0.
//  T2 single packet: req0 sends 3 beats, LAST_BIT on beat 3, fifo_full=0 -> grant=0001 one cycle
//     after req_valid. Exactly 3 writes with matching data, then IDLE.
//  T3 round-robin: all 4 requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0.
//     Each grant is separated by one IDLE cycle.
//  T4 full backpressure: fifo_full=1 for 5 cycles in mid-packet -> fifo_wr_en=0 and req_ready=0
//     for those cycles. Timeout does not fire. The packet completes intact after full drops.
//  T5 timeout: TIMEOUT=4, owner drops req_valid after beat 1 -> release after 4 idle cycles,
//     timeout_err=1. The next requester is granted. err_clr returns timeout_err to 0.
//  T6 async reset in mid-packet of req2 -> outputs 0 immediately.
//     After reset release, arbitration restarts from index 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Packet-level round-robin arbiter that shares one sfifo write port among NREQ
// packet sources. A grant is held until the owner's end-of-packet beat is written,
// or until the owner has stayed idle for TIMEOUT consecutive cycles.
module fifo_wr_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 18,
  parameter int LAST_BIT   = 16,
  parameter int TO_WIDTH   = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_WIDTH-1:0]      fifo_din,
  output logic [NREQ-1:0]            grant,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [OW-1:0]         owner;
  logic [OW-1:0]         rr_ptr;
  logic [OW-1:0]         owner_inc;
  logic [OW-1:0]         pick;
  logic                  pick_found;
  logic [TO_WIDTH-1:0]   to_cnt;
  logic [TO_WIDTH-1:0]   to_inc;
  logic                  owner_valid;
  logic                  wr;
  logic                  last_beat;
  logic                  to_hit;
  logic [DATA_WIDTH-1:0] beats [NREQ];
  logic [DATA_WIDTH-1:0] owner_data;

  // Split the flat request bus into one beat per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      beats[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_data  = beats[owner];
  assign owner_valid = req_valid[owner];
  assign last_beat   = owner_data[LAST_BIT];
  assign wr          = (state == GRANT) && owner_valid && !fifo_full;
  assign owner_inc   = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
  assign to_inc      = to_cnt + TO_WIDTH'(1);

  // The timeout fires on the idle cycle that brings the counter up to TIMEOUT,
  // so a write can never coincide with a forced release.
  assign to_hit = (TIMEOUT != 0) && (state == GRANT) && !owner_valid &&
                  (to_inc == TO_WIDTH'(TIMEOUT));

  // Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    int            idx;
    logic [OW-1:0] cand;
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NREQ;
      cand = OW'(idx);
      if (!pick_found && req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  // Grant and ready decode from the registered owner; zero whenever idle.
  always_comb begin
    grant     = '0;
    req_ready = '0;
    if (state == GRANT) begin
      grant[owner]     = 1'b1;
      req_ready[owner] = !fifo_full;
    end
  end

  assign busy       = (state == GRANT);
  assign fifo_wr_en = wr;
  assign fifo_din   = wr ? owner_data : '0;

  // Arbitration FSM with round-robin pointer, idle-timeout counter and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (to_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (pick_found) begin
            owner <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (wr && last_beat) begin
            state  <= IDLE;
            rr_ptr <= owner_inc;
            to_cnt <= '0;
          end else if (to_hit) begin
            state  <= IDLE;
            rr_ptr <= owner_inc;
            to_cnt <= '0;
          end else if (wr) begin
            to_cnt <= '0;
          end else if (!owner_valid) begin
            to_cnt <= to_inc;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Table-driven bench for fifo_wr_arbiter with a queue scoreboard for written beats.
// Each table row is one clock cycle: inputs driven just after the rising edge,
// outputs sampled on the falling edge.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 18;
  localparam int LB   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_din;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout_err;
  logic              err_clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] v;
    logic [3:0] last;
    logic       full;
    logic       clr;
    logic [3:0] eg;
    logic       ewr;
    logic [3:0] erdy;
    logic       ebusy;
    logic       eerr;
  } vec_t;

  vec_t        vq[$];
  logic [DW-1:0] sbq[$];
  int          seqn [NREQ];

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DATA_WIDTH(DW), .LAST_BIT(LB), .TO_WIDTH(8), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .grant(grant), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] mkBeat(input int idx, input int s, input logic last);
    return {1'b0, last, 8'(idx), 8'(s)};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] v, input logic [3:0] last, input logic full,
                        input logic clr, input logic [3:0] eg, input logic ewr,
                        input logic [3:0] erdy, input logic ebusy, input logic eerr);
    vec_t t;
    t.v = v; t.last = last; t.full = full; t.clr = clr; t.eg = eg;
    t.ewr = ewr; t.erdy = erdy; t.ebusy = ebusy; t.eerr = eerr;
    vq.push_back(t);
  endtask

  function automatic int onehotIdx(input logic [3:0] g);
    int r;
    r = 0;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t t);
    int o;
    @(posedge clk);
    #1;
    req_valid = t.v;
    fifo_full = t.full;
    err_clr   = t.clr;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = mkBeat(i, seqn[i], t.last[i]);
    if (t.ewr) begin
      o = onehotIdx(t.eg);
      sbq.push_back(mkBeat(o, seqn[o], t.last[o]));
    end
  endtask

  task automatic checkOutput(input vec_t t, input int row);
    logic [10:0] act;
    logic [10:0] exp;
    @(negedge clk);
    act = {grant, busy, req_ready, fifo_wr_en, timeout_err};
    exp = {t.eg, t.ebusy, t.erdy, t.ewr, t.eerr};
    cmp($sformatf("row%0d grant/busy/ready/wr/err", row), 32'(act), 32'(exp));
    if (fifo_wr_en) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL row%0d unexpected_write actual=%h required=none", row, fifo_din);
      end else begin
        cmp($sformatf("row%0d fifo_din", row), 32'(fifo_din), 32'(sbq.pop_front()));
      end
    end else begin
      cmp($sformatf("row%0d fifo_din_idle", row), 32'(fifo_din), 32'h0);
    end
    if (t.ewr) seqn[onehotIdx(t.eg)]++;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) seqn[i] = 0;

    // single packet from req0, three beats
    addVec(4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 4'b0001, 1, 0);
    addVec(4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 4'b0001, 1, 0);
    addVec(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 4'b0001, 1, 0);
    addVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    // round robin with one-beat packets, pointer starts at 1 and wraps
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0010, 1, 4'b0010, 1, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0100, 1, 4'b0100, 1, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b1000, 1, 4'b1000, 1, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b1111, 4'b1111, 0, 0, 4'b0001, 1, 4'b0001, 1, 0);
    addVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    // req1 packet stalled by fifo_full for five cycles
    addVec(4'b0010, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b0010, 4'b0000, 0, 0, 4'b0010, 1, 4'b0010, 1, 0);
    for (int i = 0; i < 5; i++)
      addVec(4'b0010, 4'b0000, 1, 0, 4'b0010, 0, 4'b0000, 1, 0);
    addVec(4'b0010, 4'b0000, 0, 0, 4'b0010, 1, 4'b0010, 1, 0);
    addVec(4'b0010, 4'b0010, 0, 0, 4'b0010, 1, 4'b0010, 1, 0);
    addVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    // req2 stalls after one beat; timeout with err_clr in the same cycle; req3 next
    addVec(4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b1100, 4'b0000, 0, 0, 4'b0100, 1, 4'b0100, 1, 0);
    addVec(4'b1000, 4'b0000, 0, 0, 4'b0100, 0, 4'b0100, 1, 0);
    addVec(4'b1000, 4'b0000, 0, 0, 4'b0100, 0, 4'b0100, 1, 0);
    addVec(4'b1000, 4'b0000, 0, 0, 4'b0100, 0, 4'b0100, 1, 0);
    addVec(4'b1000, 4'b0000, 0, 1, 4'b0100, 0, 4'b0100, 1, 0);
    addVec(4'b1000, 4'b1000, 0, 0, 4'b0000, 0, 4'b0000, 0, 1);
    addVec(4'b1000, 4'b1000, 0, 0, 4'b1000, 1, 4'b1000, 1, 1);
    addVec(4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 0, 1);
    addVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    // move pointer to 1, then start a req2 packet that reset will abort
    addVec(4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 4'b0001, 1, 0);
    addVec(4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 4'b0100, 1, 0);
    // after reset arbitration restarts from index 0
    addVec(4'b0011, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);
    addVec(4'b0011, 4'b0011, 0, 0, 4'b0001, 1, 4'b0001, 1, 0);
    addVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0);

    // reset with every requester valid
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = mkBeat(i, 0, 1'b1);
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cmp("reset grant", 32'(grant), 32'h0);
    cmp("reset wr_en/busy/err", 32'({fifo_wr_en, busy, timeout_err}), 32'h0);
    cmp("reset ready/din", 32'({req_ready, fifo_din}), 32'h0);
    rst = 1'b0;
    req_valid = '0;

    for (int r = 0; r < 38; r++) begin
      applyStimulus(vq[r]);
      checkOutput(vq[r], r);
    end

    // async reset in the middle of req2's packet
    @(posedge clk);
    #1;
    #2 rst = 1'b1;
    #1;
    cmp("async_reset immediate", 32'({grant, busy, req_ready, fifo_wr_en, timeout_err}), 32'h0);
    cmp("async_reset din", 32'(fifo_din), 32'h0);
    @(negedge clk);
    cmp("async_reset hold", 32'({grant, busy, req_ready, fifo_wr_en}), 32'h0);
    rst = 1'b0;
    req_valid = '0;

    for (int r = 38; r < vq.size(); r++) begin
      applyStimulus(vq[r]);
      checkOutput(vq[r], r);
    end

    cmp("scoreboard drained", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
